// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - program counter and next-PC selection for the instruction fetch stage.
// Optional macro DELAY_SLOT_EN: taken redirects execute one delay-slot instruction first.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_000C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic        zero,
    input  logic [15:0] imm16,
    input  logic [25:0] target26,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [9:0]  im_addr,
    output logic [31:0] inst_cnt,
    output logic        align_err
);

    localparam logic [1:0] SEL_SEQ  = 2'b00;
    localparam logic [1:0] SEL_BEQ  = 2'b01;
    localparam logic [1:0] SEL_JUMP = 2'b10;
    localparam logic [1:0] SEL_JR   = 2'b11;

    logic [31:0] pc_q;
    logic [31:0] cnt_q;
    logic        err_q;

    logic [31:0] br_target;
    logic [31:0] redirect_target;
    logic        taken;
    logic        misaligned;
    logic [31:0] next_pc;
    logic        set_err;

    assign pc        = pc_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign im_addr   = pc_q[11:2];
    assign inst_cnt  = cnt_q;
    assign align_err = err_q;

    // Targets are always derived from the issuing instruction's own pc+4.
    always_comb begin
        br_target       = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
        redirect_target = pc_plus4;
        taken           = 1'b0;
        misaligned      = 1'b0;
        unique case (npc_sel)
            SEL_SEQ: begin
                redirect_target = pc_plus4;
                taken           = 1'b0;
            end
            SEL_BEQ: begin
                redirect_target = br_target;
                taken           = zero;
            end
            SEL_JUMP: begin
                redirect_target = {pc_plus4[31:28], target26, 2'b00};
                taken           = 1'b1;
            end
            SEL_JR: begin
                redirect_target = {rs_data[31:2], 2'b00};
                taken           = 1'b1;
                misaligned      = (rs_data[1:0] != 2'b00);
            end
        endcase
    end

`ifdef DELAY_SLOT_EN
    logic        pend_valid;
    logic [31:0] pend_target;
    logic        next_pend_valid;
    logic [31:0] next_pend_target;

    // While a target is pending, this cycle is the delay slot and its own request is dropped.
    always_comb begin
        next_pc          = pc_plus4;
        set_err          = 1'b0;
        next_pend_valid  = 1'b0;
        next_pend_target = pend_target;
        if (pend_valid) begin
            next_pc = pend_target;
        end else if (taken) begin
            next_pc          = pc_plus4;
            next_pend_valid  = 1'b1;
            next_pend_target = redirect_target;
            set_err          = misaligned;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            cnt_q       <= 32'd0;
            err_q       <= 1'b0;
            pend_valid  <= 1'b0;
            pend_target <= 32'd0;
        end else if (!stall) begin
            pc_q        <= next_pc;
            cnt_q       <= cnt_q + 32'd1;
            err_q       <= err_q | set_err;
            pend_valid  <= next_pend_valid;
            pend_target <= next_pend_target;
        end
    end
`else
    always_comb begin
        next_pc = taken ? redirect_target : pc_plus4;
        set_err = misaligned;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            cnt_q <= 32'd0;
            err_q <= 1'b0;
        end else if (!stall) begin
            pc_q  <= next_pc;
            cnt_q <= cnt_q + 32'd1;
            err_q <= err_q | set_err;
        end
    end
`endif

endmodule
